// File: rtl/nco_pkg.sv
// Shared constants and helpers for the multi-channel phase accumulator.
package nco_pkg;

    localparam logic CFG_SEL_STEP   = 1'b0;
    localparam logic CFG_SEL_OFFSET = 1'b1;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_bits(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/multi_phase_accumulator_if.sv
// Configuration port: valid/ready shadow-register write plus the commit request.
interface multi_phase_accumulator_if #(
    parameter int ACC_WIDTH = 32,
    parameter int NUM_CH    = 4
);
    import nco_pkg::*;

    localparam int CH_BITS = ch_bits(NUM_CH);

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CH_BITS-1:0]   cfg_ch;
    logic                 cfg_sel;
    logic [ACC_WIDTH-1:0] cfg_data;
    logic                 update;

    modport master (
        output cfg_valid, cfg_ch, cfg_sel, cfg_data, update,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_sel, cfg_data, update,
        output cfg_ready
    );

endinterface

// File: rtl/phase_acc_channel.sv
// One NCO channel: shadow/active step and offset, wrapping accumulator,
// offset-applied truncated phase output.
module phase_acc_channel #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en_i,
    input  logic                 commit_i,
    input  logic                 wr_step_i,
    input  logic                 wr_off_i,
    input  logic [ACC_WIDTH-1:0] wr_data_i,
    input  logic                 clr_i,
    output logic [OUT_WIDTH-1:0] phase_o,
    output logic                 wrap_o
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] step_act_q, off_act_q, step_sh_q, off_sh_q;
    logic [OUT_WIDTH-1:0] phase_q, phase_d;
    logic                 wrap_q, wrap_d;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, step_act_q};

    always_comb begin
        acc_d   = acc_q;
        wrap_d  = 1'b0;
        phase_d = phase_q;
        if (en_i) begin
            acc_d   = sum[ACC_WIDTH-1:0];
            wrap_d  = sum[ACC_WIDTH];
            phase_d = OUT_WIDTH'((acc_q + off_act_q) >> (ACC_WIDTH - OUT_WIDTH));
        end
        // Clear wins over accumulate but leaves the phase output path alone.
        if (clr_i) begin
            acc_d  = '0;
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            step_act_q <= '0;
            off_act_q  <= '0;
            step_sh_q  <= '0;
            off_sh_q   <= '0;
            phase_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            wrap_q  <= wrap_d;
            phase_q <= phase_d;
            if (wr_step_i) step_sh_q <= wr_data_i;
            if (wr_off_i)  off_sh_q  <= wr_data_i;
            // Nonblocking copy: a same-edge shadow write lands after the commit.
            if (commit_i) begin
                step_act_q <= step_sh_q;
                off_act_q  <= off_sh_q;
            end
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = wrap_q;

endmodule

// File: rtl/multi_phase_accumulator.sv
// Multi-channel phase accumulator: config decode, coherent commit of all
// channels on an enable edge, and the per-channel datapath array.
module multi_phase_accumulator
    import nco_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int NUM_CH    = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    multi_phase_accumulator_if.slave    cfg,
    input  logic [NUM_CH-1:0]           clr,
    output logic [NUM_CH*OUT_WIDTH-1:0] phase_out,
    output logic                        out_valid,
    output logic [NUM_CH-1:0]           wrap
);

    localparam int CH_BITS = ch_bits(NUM_CH);

    logic pending_q, pending_d;
    logic commit;
    logic accept;
    logic out_valid_q;

    assign cfg.cfg_ready = ~pending_q;
    assign accept        = cfg.cfg_valid & ~pending_q;
    assign commit        = en & (cfg.update | pending_q);

    always_comb begin
        pending_d = pending_q | cfg.update;
        if (commit) pending_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= en;
        end
    end

    assign out_valid = out_valid_q;

    // Writes to channel indices beyond NUM_CH match no lane and are dropped.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit = accept && (cfg.cfg_ch == CH_BITS'(c));

        phase_acc_channel #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .en_i      (en),
            .commit_i  (commit),
            .wr_step_i (hit && (cfg.cfg_sel == CFG_SEL_STEP)),
            .wr_off_i  (hit && (cfg.cfg_sel == CFG_SEL_OFFSET)),
            .wr_data_i (cfg.cfg_data),
            .clr_i     (clr[c]),
            .phase_o   (phase_out[c*OUT_WIDTH +: OUT_WIDTH]),
            .wrap_o    (wrap[c])
        );
    end

endmodule

// File: tb/tb_multi_phase_accumulator.sv
// Directed scoreboard bench: stimulus queues expected phase/wrap per en edge,
// a monitor pops and compares whenever out_valid is seen.
module tb_multi_phase_accumulator;
    import nco_pkg::*;

    localparam int AW = 32;
    localparam int OW = 16;
    localparam int NC = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              en = 1'b0;
    logic [NC-1:0]     clr = '0;
    logic [NC*OW-1:0]  phase_out;
    logic              out_valid;
    logic [NC-1:0]     wrap;

    multi_phase_accumulator_if #(.ACC_WIDTH(AW), .NUM_CH(NC)) cif ();

    multi_phase_accumulator #(
        .ACC_WIDTH (AW),
        .OUT_WIDTH (OW),
        .NUM_CH    (NC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .cfg       (cif.slave),
        .clr       (clr),
        .phase_out (phase_out),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC-1:0]    w;
        logic [NC*OW-1:0] ph;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;
    int   oidx = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s (out #%0d) actual=%0h required=%0h", name, oidx, act, req);
        end
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("phase_out", 64'(phase_out), 64'(e.ph));
                chk("wrap", 64'(wrap), 64'(e.w));
            end
            oidx++;
        end
    end

    task automatic cyc(input logic e, input logic u, input logic [NC-1:0] c,
                       input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                       input logic [NC-1:0] w);
        exp_t x;
        @(negedge clk);
        en = e;
        cif.update = u;
        cif.cfg_valid = 1'b0;
        clr = c;
        if (e) begin
            x.w  = w;
            x.ph = {p2, p1, p0};
            q.push_back(x);
        end
    endtask

    task automatic cfgw(input logic [1:0] ch, input logic sel, input logic [31:0] d, input logic exp_rdy);
        @(negedge clk);
        en = 1'b0;
        cif.update = 1'b0;
        clr = '0;
        cif.cfg_valid = 1'b1;
        cif.cfg_ch = ch;
        cif.cfg_sel = sel;
        cif.cfg_data = d;
        #1 chk("cfg_ready", 64'(cif.cfg_ready), 64'(exp_rdy));
    endtask

    initial begin
        cif.cfg_valid = 1'b0;
        cif.cfg_ch = '0;
        cif.cfg_sel = 1'b0;
        cif.cfg_data = '0;
        cif.update = 1'b0;

        #3;
        chk("rst_phase_out", 64'(phase_out), 64'd0);
        chk("rst_wrap", 64'(wrap), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cfg_ready", 64'(cif.cfg_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // ch0 quarter-turn step, ch1 half-turn offset, commit with update+en
        cfgw(0, CFG_SEL_STEP,   32'h4000_0000, 1'b1);
        cfgw(1, CFG_SEL_OFFSET, 32'h8000_0000, 1'b1);
        cyc(1, 1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h0000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h4000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h8000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'hC000, 16'h8000, 16'h0000, 3'b001);
        cyc(1, 0, 3'b000, 16'h0000, 16'h8000, 16'h0000, 3'b000);

        // ch2 step written but never committed: ch2 stays at 0
        cfgw(2, CFG_SEL_STEP, 32'h1000_0000, 1'b1);
        cyc(1, 0, 3'b000, 16'h4000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h8000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'hC000, 16'h8000, 16'h0000, 3'b001);
        cyc(1, 0, 3'b000, 16'h0000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h4000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h8000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'hC000, 16'h8000, 16'h0000, 3'b001);
        cyc(1, 0, 3'b000, 16'h0000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h4000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h8000, 16'h8000, 16'h0000, 3'b000);

        // update with en low: pending blocks writes until the next en edge
        cyc(0, 1, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
        for (int i = 0; i < 5; i++) cfgw(2, CFG_SEL_OFFSET, 32'h1234_0000, 1'b0);
        cyc(1, 0, 3'b000, 16'hC000, 16'h8000, 16'h0000, 3'b001);
        @(posedge clk);
        #2 chk("cfg_ready_after_commit", 64'(cif.cfg_ready), 64'd1);
        cyc(1, 0, 3'b000, 16'h0000, 16'h8000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h4000, 16'h8000, 16'h1000, 3'b000);
        cyc(1, 0, 3'b000, 16'h8000, 16'h8000, 16'h2000, 3'b000);

        // clear ch0 on the edge that would otherwise wrap
        cyc(1, 0, 3'b001, 16'hC000, 16'h8000, 16'h3000, 3'b000);
        cyc(1, 0, 3'b000, 16'h0000, 16'h8000, 16'h4000, 3'b000);
        cyc(1, 0, 3'b000, 16'h4000, 16'h8000, 16'h5000, 3'b000);

        // out-of-range channel write is accepted and changes nothing
        cfgw(3, CFG_SEL_STEP, 32'hFFFF_FFFF, 1'b1);
        cyc(1, 1, 3'b000, 16'h8000, 16'h8000, 16'h6000, 3'b000);
        cyc(1, 0, 3'b000, 16'hC000, 16'h8000, 16'h7000, 3'b001);
        cyc(1, 0, 3'b000, 16'h0000, 16'h8000, 16'h8000, 3'b000);

        // asynchronous reset mid-sweep
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_phase_out", 64'(phase_out), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_wrap", 64'(wrap), 64'd0);
        @(negedge clk);
        en = 1'b0;
        reset_n = 1'b1;

        // pending update is dropped by reset
        cyc(0, 1, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
        @(posedge clk);
        #2 chk("pending_cfg_ready", 64'(cif.cfg_ready), 64'd0);
        reset_n = 1'b0;
        #1 chk("rst_clears_pending", 64'(cif.cfg_ready), 64'd1);
        @(negedge clk);
        cif.update = 1'b0;
        reset_n = 1'b1;
        cyc(1, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000);
        cyc(1, 0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000);
        cyc(0, 0, 3'b000, 16'h0, 16'h0, 16'h0, 3'b000);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
